iterative_shift_unit: RTL and testbench
=======================================

// Module: iterative_shift_unit
//
// PURPOSE
//  Parametrised, multi-cycle universal shift unit for the datapath shifter stage.
//  Supports LSL, LSR, ASR and ROR by a run-time amount, one bit position per enabled clock.
//  Produces the ARM-style shifter carry-out and uses a start/busy/done handshake.
//  Sits between register-file read data and the ALU operand-2 input.
//
// PARAMETERS
//  WIDTH    8  data width in bits (>= 2)
//  SHAMT_W  4  shift-amount width; amounts 0 .. 2**SHAMT_W-1 accepted, including > WIDTH
//
// PORTS
//  clock      in   1        rising-edge clock
//  reset_n    in   1        asynchronous, active-low reset
//  enable     in   1        clock enable; 0 freezes all state and outputs
//  start      in   1        request a shift; sampled only in IDLE with enable=1
//  op         in   2        00 LSL, 01 LSR, 10 ASR, 11 ROR
//  data_in    in   WIDTH    operand, latched on accepted start
//  shamt      in   SHAMT_W  shift amount, latched on accepted start
//  carry_in   in   1        carry flag, latched on accepted start
//  data_out   out  WIDTH    working register; result valid while done=1
//  carry_out  out  1        last bit shifted or rotated out; carry_in if shamt=0
//  busy       out  1        1 in SHIFT and DONE states
//  done       out  1        one-cycle pulse; result valid
//
// BEHAVIOUR
//  - Reset (reset_n=0, asynchronous):
//    - state=IDLE; data_out=0, carry_out=0, busy=0, done=0, count=0.
//    - Asserting reset mid-shift aborts the operation immediately; no done pulse follows.
//  - Registered FSM with states IDLE, SHIFT, DONE.
//    - All transitions and register updates need enable=1, except DONE->IDLE, which is unconditional.
//  - IDLE:
//    - On start=1: data_out<=data_in, carry_out<=carry_in, latch op, count<=shamt.
//    - Next state is SHIFT if shamt!=0, otherwise DONE.
//    - With start=0: all registers hold.
//  - SHIFT, on each enabled edge:
//    - LSL: carry_out<=d[W-1]; d<={d[W-2:0],1'b0}.
//    - LSR: carry_out<=d[0];   d<={1'b0,d[W-1:1]}.
//    - ASR: carry_out<=d[0];   d<={d[W-1],d[W-1:1]}.
//    - ROR: carry_out<=d[0];   d<={d[0],d[W-1:1]}.
//    - count<=count-1. When count==1 at the edge, next state is DONE.
//  - DONE:
//    - done=1 and busy=1 for exactly one cycle; data_out and carry_out hold.
//    - Next edge goes to IDLE.
//  - Latency: done is high in the cycle after edge E0+shamt, where E0 is the start-accept edge.
//    - Total = shamt+1 cycles when enable is held high; each enable=0 cycle adds one.
//  - Amounts >= WIDTH keep stepping one bit per edge.
//    - LSL/LSR reach 0 with carry_out=0 after WIDTH+1 steps.
//    - ASR saturates to all sign bits.
//    - ROR wraps modulo WIDTH.
//  - start asserted while busy=1 (SHIFT or DONE) is ignored, not queued.
//  - op, data_in, shamt and carry_in changing during SHIFT have no effect.
//  - After DONE, data_out and carry_out hold until the next accepted start or reset.
//
// TESTING (WIDTH=8, SHAMT_W=4)
//  1. reset_n=0 mid-SHIFT (ROR 0x55 by 7, after 3 edges)
//     -> data_out=0x00, carry_out=0, busy=0, done=0 at once;
//        after release, stays IDLE with no done.
//  2. LSL data_in=0x81 shamt=1 carry_in=0
//     -> after 2 edges: done=1, data_out=0x02, carry_out=1; next cycle done=0, busy=0.
//  3. ASR data_in=0x90 shamt=3
//     -> done in cycle after edge E0+3: data_out=0xF2, carry_out=0.
//     ROR data_in=0x01 shamt=9
//     -> data_out=0x80, carry_out=1 after edge E0+9.
//  4. LSR data_in=0xA5 shamt=0 carry_in=1
//     -> done in cycle after E0: data_out=0xA5, carry_out=1, no SHIFT state entered.
//  5. LSR 0xF0 by 15 with enable=0 for 2 cycles mid-shift
//     -> outputs frozen while enable=0; done 2 cycles later than nominal;
//        data_out=0x00, carry_out=0.
//  6. start=1 pulsed while busy (new data_in=0xFF)
//     -> ignored; the in-flight result is unchanged;
//        start re-asserted in IDLE is accepted normally.

Source files
------------

// File: rtl/iterative_shift_unit.sv
// Multi-cycle LSL/LSR/ASR/ROR shifter, one bit per enabled clock, with ARM-style carry-out.
// Latency shamt+1 cycles at full enable; start is ignored while busy, and enable=0 stalls everything.
module iterative_shift_unit #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               carry_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               carry_out,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] count;
  logic [WIDTH-1:0]   shift_dat;
  logic               shift_cry;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DONE always returns to IDLE, even with enable low, so done is a true single-cycle pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable && start) begin
          state_nxt = (shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (enable && (count == SHAMT_W'(1))) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shift_dat = data_out;
    shift_cry = data_out[0];
    case (op_q)
      OP_LSL: begin
        shift_dat = {data_out[WIDTH-2:0], 1'b0};
        shift_cry = data_out[WIDTH-1];
      end
      OP_LSR:  shift_dat = {1'b0, data_out[WIDTH-1:1]};
      OP_ASR:  shift_dat = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
      OP_ROR:  shift_dat = {data_out[0], data_out[WIDTH-1:1]};
      default: shift_dat = data_out;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out  <= '0;
      carry_out <= 1'b0;
      op_q      <= OP_LSL;
      count     <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (start) begin
            data_out  <= data_in;
            carry_out <= carry_in;
            op_q      <= op;
            count     <= shamt;
          end
        end
        SHIFT: begin
          data_out  <= shift_dat;
          carry_out <= shift_cry;
          count     <= count - SHAMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Directed bench for iterative_shift_unit: expected results queued at start, checked on done.
module tb_iterative_shift_unit;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       start;
  logic [1:0] op;
  logic [7:0] data_in;
  logic [3:0] shamt;
  logic       carry_in;
  logic [7:0] data_out;
  logic       carry_out;
  logic       busy;
  logic       done;

  typedef struct {
    logic [7:0] dat;
    logic       cry;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   errors;

  iterative_shift_unit #(.WIDTH(8), .SHAMT_W(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .start     (start),
    .op        (op),
    .data_in   (data_in),
    .shamt     (shamt),
    .carry_in  (carry_in),
    .data_out  (data_out),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drives a start for one edge; when want_done is set the expected result is queued.
  task automatic issue(input logic [1:0] o, input logic [7:0] d, input logic [3:0] sh,
                       input logic cin, input logic [7:0] ed, input logic ec,
                       input int stalls, input bit want_done);
    exp_t e;
    start    = 1'b1;
    op       = o;
    data_in  = d;
    shamt    = sh;
    carry_in = cin;
    @(posedge clock);
    #1;
    e.dat = ed;
    e.cry = ec;
    e.cyc = cyc + int'(sh) + stalls;
    if (want_done) exp_q.push_back(e);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(posedge clock);
      #2;
      n++;
    end
    check({name, "_idle_timeout"}, int'(busy === 1'b1), 0);
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    data_in  = 8'h00;
    shamt    = 4'd0;
    carry_in = 1'b0;
    checks   = 0;
    errors   = 0;

    fork
      forever begin
        @(negedge clock);
        if (reset_n === 1'b1 && done === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("result_data", int'(data_out), int'(e.dat));
            check("result_carry", int'(carry_out), int'(e.cry));
            check("done_cycle", cyc, e.cyc);
            check("done_busy", int'(busy), 1);
          end
        end
      end
    join_none

    #1;
    check("rst_data", int'(data_out), 0);
    check("rst_flags", int'({carry_out, busy, done}), 0);
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #2;

    // Reset mid-ROR aborts: no done may ever follow.
    issue(2'b11, 8'h55, 4'd7, 1'b0, 8'h00, 1'b0, 0, 1'b0);
    repeat (3) begin
      @(posedge clock);
      #2;
    end
    check("pre_abort_busy", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("abort_data", int'(data_out), 0);
    check("abort_flags", int'({carry_out, busy, done}), 0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    repeat (12) @(posedge clock);
    #2;
    check("abort_stays_idle", int'({busy, done}), 0);

    // LSL by 1: done pulse lasts exactly one cycle.
    issue(2'b00, 8'h81, 4'd1, 1'b0, 8'h02, 1'b1, 0, 1'b1);
    @(posedge clock);
    #2;
    check("lsl1_done_high", int'(done), 1);
    @(posedge clock);
    #2;
    check("lsl1_after_done", int'({busy, done}), 0);
    check("lsl1_hold_data", int'(data_out), 8'h02);

    issue(2'b10, 8'h90, 4'd3, 1'b0, 8'hF2, 1'b0, 0, 1'b1);
    wait_idle("asr3");
    issue(2'b11, 8'h01, 4'd9, 1'b0, 8'h80, 1'b1, 0, 1'b1);
    wait_idle("ror9");

    // Zero amount goes straight to DONE with carry_in passed through.
    issue(2'b01, 8'hA5, 4'd0, 1'b1, 8'hA5, 1'b1, 0, 1'b1);
    check("sh0_direct_done", int'({busy, done}), 3);
    wait_idle("sh0");

    // LSR by 15 with a two-cycle enable stall after four shift steps.
    issue(2'b01, 8'hF0, 4'd15, 1'b0, 8'h00, 1'b0, 2, 1'b1);
    repeat (4) begin
      @(posedge clock);
      #2;
    end
    check("pre_stall_data", int'(data_out), 8'h0F);
    enable = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #2;
      check("stall_data", int'(data_out), 8'h0F);
      check("stall_flags", int'({carry_out, busy, done}), 3'b010);
    end
    enable = 1'b1;
    wait_idle("lsr15");

    // Start held with new operands throughout busy must be ignored.
    issue(2'b00, 8'h03, 4'd4, 1'b0, 8'h30, 1'b0, 0, 1'b1);
    start    = 1'b1;
    op       = 2'b11;
    data_in  = 8'hFF;
    shamt    = 4'd1;
    carry_in = 1'b1;
    begin
      int n = 0;
      while (done !== 1'b1 && n < 50) begin
        @(posedge clock);
        #2;
        n++;
      end
      check("busy_start_timeout", int'(done === 1'b1), 1);
    end
    start = 1'b0;
    wait_idle("busy_start");
    issue(2'b11, 8'hFF, 4'd1, 1'b0, 8'hFF, 1'b1, 0, 1'b1);
    wait_idle("reaccept");

    repeat (3) @(posedge clock);
    #2;
    check("missing_done", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
